// File: rtl/tag_lookup_pkg.sv
// Shared defaults, width helper and response record for the tag lookup block.
package tag_lookup_pkg;

  localparam int TAG_BITS_DEF = 10;
  localparam int WAYS_DEF     = 4;
  localparam int SET_BITS_DEF = 6;

  // Response record is sized for the widest legal configuration
  // (16 ways, up to 16 set bits); narrower builds zero-extend into it.
  localparam int WAY_BITS_MAX = 4;
  localparam int SET_BITS_MAX = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  typedef struct packed {
    logic                    hit;
    logic [WAY_BITS_MAX-1:0] way;
    logic                    multi;
    logic [WAY_BITS_MAX-1:0] victim;
    logic [SET_BITS_MAX-1:0] set;
  } resp_t;

endpackage

// File: rtl/tag_way_compare.sv
// One way's tag comparator: exact equality, qualified by the way's valid bit.
module tag_way_compare #(
  parameter int TAG_BITS = 10
) (
  input  logic [TAG_BITS-1:0] tag_a_i,
  input  logic [TAG_BITS-1:0] tag_b_i,
  input  logic                valid_i,
  output logic                match_o
);

  assign match_o = valid_i && (tag_a_i == tag_b_i);

endmodule

// File: rtl/tag_lookup.sv
// Set-associative tag lookup: two-stage pipeline producing hit/way/multi-hit
// and a replacement victim (first free way, else per-set round-robin).
module tag_lookup
  import tag_lookup_pkg::*;
#(
  parameter  int TAG_BITS = TAG_BITS_DEF,
  parameter  int WAYS     = WAYS_DEF,
  parameter  int SET_BITS = SET_BITS_DEF,
  localparam int WAY_BITS = clog2(WAYS),
  localparam int SETS     = 2 ** SET_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SET_BITS-1:0]      req_set,
  input  logic [TAG_BITS-1:0]      req_tag,
  input  logic [WAYS*TAG_BITS-1:0] way_tags,
  input  logic [WAYS-1:0]          way_valid,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic [WAY_BITS-1:0]      resp_way,
  output logic                     resp_multi,
  output logic [WAY_BITS-1:0]      resp_victim,
  output logic [SET_BITS-1:0]      resp_set
);

  logic                           s1_valid_q;
  logic [SET_BITS-1:0]            s1_set_q;
  logic [TAG_BITS-1:0]            s1_tag_q;
  logic [WAYS-1:0][TAG_BITS-1:0]  s1_tags_q;
  logic [WAYS-1:0]                s1_wvld_q;
  logic                           resp_valid_q;
  resp_t                          resp_q, resp_d;
  logic [SETS-1:0][WAY_BITS-1:0]  rr_q;

  logic [WAYS-1:0]     match;
  logic [WAY_BITS-1:0] hit_way, free_way, victim;
  logic                hit, multi, all_valid, s1_adv, rr_bump;

  assign s1_adv    = !resp_valid_q || resp_ready;
  assign req_ready = !s1_valid_q || s1_adv;

  for (genvar g = 0; g < WAYS; g++) begin : g_cmp
    tag_way_compare #(.TAG_BITS(TAG_BITS)) u_cmp (
      .tag_a_i (s1_tags_q[g]),
      .tag_b_i (s1_tag_q),
      .valid_i (s1_wvld_q[g]),
      .match_o (match[g])
    );
  end

  // Lowest-index priority encode of matches and of free (invalid) ways.
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i])      hit_way  = WAY_BITS'(i);
      if (!s1_wvld_q[i]) free_way = WAY_BITS'(i);
    end
  end

  assign hit       = |match;
  assign multi     = |(match & (match - WAYS'(1)));
  assign all_valid = &s1_wvld_q;
  // The pointer was already advanced by any older request to this set at the
  // edge it left S1, so reading it here is never stale.
  assign victim    = all_valid ? rr_q[s1_set_q] : free_way;
  assign rr_bump   = s1_valid_q && s1_adv && !hit && all_valid;

  // Assemble the S2 record from the S1 result.
  always_comb begin
    resp_d        = '0;
    resp_d.hit    = hit;
    resp_d.way    = WAY_BITS_MAX'(hit_way);
    resp_d.multi  = multi;
    resp_d.victim = WAY_BITS_MAX'(victim);
    resp_d.set    = SET_BITS_MAX'(s1_set_q);
  end

  // S1: capture request together with the set's tags/valids on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_set_q   <= '0;
      s1_tag_q   <= '0;
      s1_tags_q  <= '0;
      s1_wvld_q  <= '0;
    end else if (req_ready) begin
      s1_valid_q <= req_valid;
      if (req_valid) begin
        s1_set_q  <= req_set;
        s1_tag_q  <= req_tag;
        s1_tags_q <= way_tags;
        s1_wvld_q <= way_valid;
      end
    end
  end

  // S2: output registers, frozen while a response waits for resp_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else if (s1_adv) begin
      resp_valid_q <= s1_valid_q;
      if (s1_valid_q) resp_q <= resp_d;
    end
  end

  // Per-set round-robin pointer: advances only on a miss with no free way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else if (rr_bump) rr_q[s1_set_q] <= rr_q[s1_set_q] + WAY_BITS'(1);
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_q.hit;
  assign resp_way    = resp_q.way[WAY_BITS-1:0];
  assign resp_multi  = resp_q.multi;
  assign resp_victim = resp_q.victim[WAY_BITS-1:0];
  assign resp_set    = resp_q.set[SET_BITS-1:0];

  // Upper bits of the wide record are always zero for narrow builds.
  logic resp_unused;
  assign resp_unused = ^{resp_q.way, resp_q.victim, resp_q.set};

endmodule

// File: tb/tb_tag_lookup.sv
// Directed bench for tag_lookup (TAG_BITS=10, WAYS=4, SET_BITS=6).
module tb_tag_lookup;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [5:0]  req_set;
  logic [9:0]  req_tag;
  logic [39:0] way_tags;
  logic [3:0]  way_valid;
  logic        resp_valid, resp_ready, resp_hit, resp_multi;
  logic [1:0]  resp_way, resp_victim;
  logic [5:0]  resp_set;

  int n_cmp = 0;
  int n_err = 0;

  tag_lookup #(.TAG_BITS(10), .WAYS(4), .SET_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_tag(req_tag),
    .way_tags(way_tags), .way_valid(way_valid),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_multi(resp_multi),
    .resp_victim(resp_victim), .resp_set(resp_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] pk(input logic [9:0] t0, t1, t2, t3);
    return {t3, t2, t1, t0};
  endfunction

  task automatic drive(input logic [5:0] s, input logic [9:0] t,
                       input logic [39:0] tags, input logic [3:0] vld);
    req_valid = 1'b1;
    req_set   = s;
    req_tag   = t;
    way_tags  = tags;
    way_valid = vld;
  endtask

  // Single request with resp_ready high; checks 2-cycle latency and fields.
  task automatic do_req(input string nm, input logic [5:0] s, input logic [9:0] t,
                        input logic [39:0] tags, input logic [3:0] vld,
                        input logic eh, input logic [1:0] ew, input logic em,
                        input logic [1:0] ev);
    @(negedge clk);
    drive(s, t, tags, vld);
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, ".early"}, resp_valid, 1'b0);
    @(negedge clk);
    chk({nm, ".valid"},  resp_valid,  1'b1);
    chk({nm, ".hit"},    resp_hit,    eh);
    chk({nm, ".way"},    resp_way,    ew);
    chk({nm, ".multi"},  resp_multi,  em);
    chk({nm, ".victim"}, resp_victim, ev);
    chk({nm, ".set"},    resp_set,    s);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_set = '0; req_tag = '0;
    way_tags = '0; way_valid = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.resp_valid", resp_valid, 1'b0);
    chk("rst.hit", resp_hit, 1'b0);
    chk("rst.way", resp_way, 2'd0);
    chk("rst.multi", resp_multi, 1'b0);
    chk("rst.victim", resp_victim, 2'd0);
    chk("rst.set", resp_set, 6'd0);
    rst_n = 1'b1;
    #1 chk("rst.req_ready", req_ready, 1'b1);

    // Basic hit in way 1.
    do_req("hit", 6'd0, 10'h2A5, pk(10'h111, 10'h2A5, 10'h3FF, 10'h000), 4'hF,
           1'b1, 2'd1, 1'b0, 2'd0);
    // 0x3FF & 0x3FE would look like a match under AND; must miss.
    do_req("andeq", 6'd1, 10'h3FF, pk(10'h3FE, 10'h001, 10'h002, 10'h003), 4'hF,
           1'b0, 2'd0, 1'b0, 2'd0);
    // Matching tag but invalid way is not a hit; free way 2 is the victim.
    do_req("invmatch", 6'd2, 10'h123, pk(10'h000, 10'h001, 10'h123, 10'h003), 4'hB,
           1'b0, 2'd0, 1'b0, 2'd2);
    // Ways 1 and 3 both match.
    do_req("multi", 6'd0, 10'h055, pk(10'h100, 10'h055, 10'h200, 10'h055), 4'hF,
           1'b1, 2'd1, 1'b1, 2'd0);

    // Round-robin victims on set 5.
    for (int i = 0; i < 5; i++)
      do_req($sformatf("rr%0d", i), 6'd5, 10'h0AA,
             pk(10'h300, 10'h301, 10'h302, 10'h303), 4'hF,
             1'b0, 2'd0, 1'b0, 2'(i % 4));
    // Free way 2 wins and leaves the pointer at 1.
    do_req("rrfree", 6'd5, 10'h0AA, pk(10'h300, 10'h301, 10'h302, 10'h303), 4'hB,
           1'b0, 2'd0, 1'b0, 2'd2);
    do_req("rrkeep", 6'd5, 10'h0AA, pk(10'h300, 10'h301, 10'h302, 10'h303), 4'hF,
           1'b0, 2'd0, 1'b0, 2'd1);

    // Back-to-back misses to one set must see the advanced pointer.
    @(negedge clk);
    drive(6'd7, 10'h0AA, pk(10'h300, 10'h301, 10'h302, 10'h303), 4'hF);
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b.v0", resp_victim, 2'd0);
    @(negedge clk);
    chk("b2b.valid1", resp_valid, 1'b1);
    chk("b2b.v1", resp_victim, 2'd1);
    @(negedge clk);
    chk("b2b.drain", resp_valid, 1'b0);

    // Backpressure: three hits identified by way index and set.
    resp_ready = 1'b0;
    drive(6'd10, 10'h010, pk(10'h010, 10'h000, 10'h000, 10'h000), 4'hF);
    @(negedge clk);
    chk("bp.ready1", req_ready, 1'b1);
    drive(6'd11, 10'h011, pk(10'h000, 10'h011, 10'h000, 10'h000), 4'hF);
    @(negedge clk);
    chk("bp.ready2", req_ready, 1'b0);
    chk("bp.valid0", resp_valid, 1'b1);
    chk("bp.set0", resp_set, 6'd10);
    drive(6'd12, 10'h012, pk(10'h000, 10'h000, 10'h012, 10'h000), 4'hF);
    repeat (2) begin
      @(negedge clk);
      chk("bp.stall_ready", req_ready, 1'b0);
      chk("bp.hold_set", resp_set, 6'd10);
      chk("bp.hold_way", resp_way, 2'd0);
      chk("bp.hold_valid", resp_valid, 1'b1);
    end
    resp_ready = 1'b1;
    #1 chk("bp.ready_comb", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp.valid1", resp_valid, 1'b1);
    chk("bp.set1", resp_set, 6'd11);
    chk("bp.way1", resp_way, 2'd1);
    @(negedge clk);
    chk("bp.valid2", resp_valid, 1'b1);
    chk("bp.set2", resp_set, 6'd12);
    chk("bp.way2", resp_way, 2'd2);
    @(negedge clk);
    chk("bp.done", resp_valid, 1'b0);

    // Reset with S1 and S2 both occupied.
    resp_ready = 1'b0;
    drive(6'd9, 10'h0AA, pk(10'h300, 10'h301, 10'h302, 10'h303), 4'hF);
    @(negedge clk);
    drive(6'd9, 10'h0AB, pk(10'h300, 10'h301, 10'h302, 10'h303), 4'hF);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mrst.pre_valid", resp_valid, 1'b1);
    rst_n = 1'b0;
    #1 chk("mrst.valid", resp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    #1 chk("mrst.ready", req_ready, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("mrst.dropped", resp_valid, 1'b0);
    end
    // Set 5 pointer was 2 before the reset; it must be back to 0.
    do_req("mrst.rr", 6'd5, 10'h0AA, pk(10'h300, 10'h301, 10'h302, 10'h303), 4'hF,
           1'b0, 2'd0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
